// File: rtl/div_unit_32.sv
// div_unit_32 -- iterative 32-bit signed/unsigned divider.
//
// One restoring shift-subtract step per clock on operand magnitudes, with a
// final sign-fix cycle. A normal divide takes 34 edges from the accepting
// edge to a visible done pulse. A divide by zero finishes after one edge.
// The results hold until the next completion or a reset.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When it is defined, a divide whose divisor magnitude exceeds the dividend
//   magnitude skips the iteration and finishes after one edge with
//   quotient = 0 and remainder = a.
module div_unit_32 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;

  // Operands captured at the accepting edge.
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        signed_r;

  // Iteration datapath.
  logic [31:0] mag_b_r;   // divisor magnitude
  logic [31:0] quo_r;     // dividend bits shift out, quotient bits shift in
  logic [31:0] rem_r;     // partial remainder (always < divisor magnitude)
  logic        neg_q_r;   // quotient must be negated at the end
  logic        neg_r_r;   // remainder must be negated at the end
  logic [5:0]  cnt_r;

  // Registered outputs.
  logic        busy_r;
  logic        done_r;
  logic [31:0] quotient_r;
  logic [31:0] remainder_r;
  logic        dbz_r;

  // Combinational helpers.
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        b_zero_s;
  logic        early_s;
  logic [32:0] shift_s;
  logic [33:0] trial_s;
  logic        fits_s;
  logic        last_step_s;

  // Magnitude of a value. This is the two's-complement absolute value when sgn
  // is set. 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic sgn);
    logic [31:0] res;
    if (sgn && v[31]) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Conditionally negate a magnitude back into two's-complement form.
  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    logic [31:0] res;
    if (neg) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Operand magnitudes, zero-divisor detect and one restoring-step trial subtract.
  always_comb begin
    mag_a_s     = mag_of(a_r, signed_r);
    mag_b_s     = mag_of(b_r, signed_r);
    b_zero_s    = (b_r == 32'd0);
    // The partial remainder shifts left and takes the next dividend bit. That
    // gives a 33-bit value, so divisors >= 0x80000000 still compare correctly.
    shift_s     = {rem_r, quo_r[31]};
    trial_s     = {1'b0, shift_s} - {2'b00, mag_b_r};
    // The subtraction is accepted only when there is no borrow. The result
    // then fits back into the 32-bit partial remainder.
    fits_s      = (trial_s[33:32] == 2'b00);
    last_step_s = (cnt_r == 6'd31);
`ifdef DIV_EARLY_OUT_EN
    early_s     = (!b_zero_s) && (mag_b_s > mag_a_s);
`else
    early_s     = 1'b0;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_PREP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PREP: begin
        if (b_zero_s || early_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_RUN: begin
        if (last_step_s) begin
          state_s = S_FIX;
        end else begin
          state_s = S_RUN;
        end
      end
      S_FIX: begin
        state_s = S_DONE;
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      signed_r    <= 1'b0;
      mag_b_r     <= 32'd0;
      quo_r       <= 32'd0;
      rem_r       <= 32'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      cnt_r       <= 6'd0;
      quotient_r  <= 32'd0;
      remainder_r <= 32'd0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= is_signed;
          end else begin
            a_r      <= a_r;
            b_r      <= b_r;
            signed_r <= signed_r;
          end
        end
        S_PREP: begin
          quo_r   <= mag_a_s;
          mag_b_r <= mag_b_s;
          rem_r   <= 32'd0;
          neg_q_r <= signed_r & (a_r[31] ^ b_r[31]);
          neg_r_r <= signed_r & a_r[31];
          cnt_r   <= 6'd0;
          if (b_zero_s) begin
            quotient_r  <= 32'hFFFF_FFFF;
            remainder_r <= a_r;
            dbz_r       <= 1'b1;
          end else if (early_s) begin
            quotient_r  <= 32'd0;
            remainder_r <= a_r;
            dbz_r       <= 1'b0;
          end else begin
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
            dbz_r       <= dbz_r;
          end
        end
        S_RUN: begin
          if (fits_s) begin
            rem_r <= trial_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= shift_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
          cnt_r <= cnt_r + 6'd1;
        end
        S_FIX: begin
          quotient_r  <= apply_sign(quo_r, neg_q_r);
          remainder_r <= apply_sign(rem_r, neg_r_r);
          dbz_r       <= 1'b0;
        end
        S_DONE: begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
          dbz_r       <= dbz_r;
        end
        default: begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
          dbz_r       <= dbz_r;
        end
      endcase
    end
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      done_r <= (state_s == S_DONE);
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: doc/div_unit_32.md
DIV_UNIT_32 -- requirements
Module: div_unit_32

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with these ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned
- a  input  32  dividend, captured when start is accepted
- b  input  32  divisor, captured when start is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle completion pulse
- quotient  output  32  LO result
- remainder  output  32  HI result
- div_by_zero  output  1  the last completed divide had b == 0

Function
REQ-002 SHALL implement states IDLE, PREP, RUN, FIX and DONE.
REQ-003 IDLE: when start=1 at edge E0, SHALL capture a, b and is_signed, then go to PREP; while start=0, SHALL stay in IDLE.
REQ-004 PREP, at edge E1:
- SHALL form the operand magnitudes (absolute value when is_signed=1).
- SHALL record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
- SHALL clear the 6-bit iteration counter and go to RUN.
- If b == 0, SHALL go to DONE instead.
REQ-005 RUN: SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (edges E2..E33), then go to FIX.
REQ-006 FIX, at edge E34:
- SHALL negate the quotient if the quotient sign is set, and the remainder if the remainder sign is set.
- SHALL register both results onto quotient/remainder and go to DONE.
REQ-007 DONE: done=1 for exactly one cycle, then SHALL return to IDLE on the next edge.
REQ-008 Latency:
- Normal divide: done SHALL be visible after the 34th edge following the accepting edge.
- Divide-by-zero: done SHALL be visible after the 1st edge following the accepting edge.
REQ-009 start SHALL be ignored in PREP, RUN, FIX and DONE; no queuing; inputs may change freely while busy=1.
REQ-010 Signed results SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; a == quotient*b + remainder SHALL hold for every b != 0.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000 and remainder=0, with no flag.
REQ-012 Divide by zero:
- SHALL give quotient=0xFFFFFFFF and remainder=a (raw captured value), with div_by_zero=1.
- div_by_zero SHALL be updated at every completion.
REQ-013 quotient, remainder and div_by_zero SHALL hold their values from one completion until the next completion or a reset.
REQ-014 Magnitude arithmetic SHALL use a 33-bit partial-remainder subtract so that divisors ≥ 0x80000000 are handled correctly.

Reset
REQ-015 When Rst=1 at a clock edge, the state SHALL become IDLE, and busy, done, quotient, remainder, div_by_zero and the counter SHALL become 0; this applies in any state.
REQ-016 Reset SHALL take priority over start; a divide interrupted by reset SHALL produce no done pulse.
REQ-017 The first start SHALL be accepted on the first edge with Rst=0 and start=1.

Configuration
REQ-018 Macro DIV_EARLY_OUT_EN, when defined:
- In PREP, if b != 0 and the divisor magnitude > the dividend magnitude, SHALL skip RUN and FIX and go directly to DONE.
- Results: quotient=0, remainder=a, div_by_zero=0, with done visible after the 1st edge following acceptance.
REQ-019 Without DIV_EARLY_OUT_EN, every b != 0 divide SHALL take the full 34-edge latency of REQ-008.

Verification
REQ-020 Unsigned divide: a=100, b=7, is_signed=0 -> quotient=14, remainder=2, done visible after edge 34, busy high from E0 through DONE.
REQ-021 Signed divide: a=0xFFFFFF9C (-100), b=7, is_signed=1 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
REQ-022 Signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0.
REQ-023 Divide by zero: a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done visible after edge 1; the next divide 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-024 Reset mid-operation: start 100/7, then assert Rst at edge 10 -> state IDLE with all outputs 0 after that edge, and no done pulse.
REQ-025 Ignored start: pulse start=1 with a=1, b=1 during RUN -> the first result is unaffected, and no second done occurs.
REQ-026 Early-out build (DIV_EARLY_OUT_EN defined): a=3, b=10 -> quotient=0, remainder=3, done visible after edge 1; without the macro, the same results appear after edge 34.
